// File: rtl/pingpong_pkg.sv
// -----------------------------------------------------------------------------
// pingpong_pkg
//
// Shared types and defaults for the two-bank (ping-pong) sample buffer
// controller and the sample RAM it drives.
//
// Contents:
//   DATA_W_DEFAULT : default sample word width (24-bit audio + 8-bit padding)
//   DEPTH_DEFAULT  : default samples per bank (power of two, >= 4)
//   pp_state_t     : write-side FSM state (FILL / STALL)
//   bank_sel_t     : one-bit bank selector
//   other_bank()   : returns the opposite bank of a selector
//
// Optional build macro used by the controller: PINGPONG_DROP_CNT_EN.
// -----------------------------------------------------------------------------
package pingpong_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int DEPTH_DEFAULT  = 256;

  // FILL  : the writer owns a bank that still has free slots.
  // STALL : both banks are full and unacknowledged; samples are dropped.
  typedef enum logic [0:0] {
    FILL  = 1'b0,
    STALL = 1'b1
  } pp_state_t;

  typedef logic bank_sel_t;

  function automatic bank_sel_t other_bank(input bank_sel_t b);
    return ~b;
  endfunction

endpackage

// File: rtl/pingpong_bank_tracker.sv
// -----------------------------------------------------------------------------
// pingpong_bank_tracker
//
// Tracks which of the two banks hold a complete, unconsumed set of samples and
// hands them to the consumer in fill order.
//
// Ports:
//   clk          : system clock
//   rst          : synchronous reset, active-high
//   set_full_i   : pulse, the last slot of bank set_bank_i was accepted
//   set_bank_i   : bank being marked full
//   buf_ack_i    : consumer pulse, finished reading rd_bank_o
//   bank_full_o  : per-bank full flags (registered)
//   rd_bank_o    : bank the consumer must read while buf_ready_o=1
//   buf_ready_o  : registered, a full bank is waiting for the consumer
//   ack_fire_o   : buf_ack_i was honoured this cycle (buf_ready_o was 1)
//
// Handshake: buf_ready_o/buf_ack_i form a valid/ack pair. An ack counts only
// in a cycle where buf_ready_o=1; it then frees rd_bank_o and advances
// rd_bank_o to the other bank. An ack while buf_ready_o=0 has no effect.
// -----------------------------------------------------------------------------
module pingpong_bank_tracker
  import pingpong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set_full_i,
  input  bank_sel_t  set_bank_i,
  input  logic       buf_ack_i,
  output logic [1:0] bank_full_o,
  output bank_sel_t  rd_bank_o,
  output logic       buf_ready_o,
  output logic       ack_fire_o
);

  logic [1:0] bank_full_q, bank_full_d;
  logic [1:0] bank_clr;
  bank_sel_t  rd_bank_q, rd_bank_d;
  logic       buf_ready_q, buf_ready_d;
  logic       ack_fire;

  assign ack_fire = buf_ack_i && buf_ready_q;

  always_comb begin
    bank_clr  = bank_full_q;
    rd_bank_d = rd_bank_q;
    if (ack_fire) begin
      bank_clr[rd_bank_q] = 1'b0;
      rd_bank_d           = other_bank(rd_bank_q);
    end

    bank_full_d = bank_clr;
    if (set_full_i) begin
      bank_full_d[set_bank_i] = 1'b1;
    end

    // Readiness follows the flags as they stood before this cycle's set, so
    // a freshly completed bank becomes visible one cycle after its flag sets,
    // i.e. after its final RAM write has landed. Acks take effect at once so
    // buf_ready never lingers high on a bank that was just released.
    buf_ready_d = bank_clr[rd_bank_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full_q <= 2'b00;
      rd_bank_q   <= 1'b0;
      buf_ready_q <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      rd_bank_q   <= rd_bank_d;
      buf_ready_q <= buf_ready_d;
    end
  end

  assign bank_full_o = bank_full_q;
  assign rd_bank_o   = rd_bank_q;
  assign buf_ready_o = buf_ready_q;
  assign ack_fire_o  = ack_fire;

endmodule

// File: rtl/pingpong_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// pingpong_buffer_ctrl
//
// Ping-pong sample RAM controller between the I2S capture path and the
// downstream consumer. The write side turns s_valid strobes into registered
// RAM writes and swaps banks when one fills; the read side (bank tracker)
// presents completed banks in fill order. When both banks are full and
// unacknowledged the writer stalls and drops samples.
//
// Parameters:
//   DATA_W : sample word width
//   DEPTH  : samples per bank (power of two, >= 4)
//   ADDR_W : in-bank address width
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   en              : capture enable (s_valid ignored and position held when 0)
//   s_valid, s_data : one-cycle sample strobe and word
//   ram_we          : RAM write enable (one cycle after an accepted sample)
//   ram_waddr       : {bank, in-bank address}
//   ram_wdata       : registered copy of the accepted sample
//   buf_ready       : a full bank is waiting for the consumer
//   rd_bank         : bank to read while buf_ready=1
//   buf_ack         : consumer finished rd_bank (honoured only if buf_ready=1)
//   buffer_full     : writer is stalled, samples are being dropped
//   overflow_sticky : a sample has been dropped since reset
//   drop_count      : saturating dropped-sample counter
//                     (present only when PINGPONG_DROP_CNT_EN is defined)
//   dbg_state       : current write FSM state
//
// Handshake: buf_ready/buf_ack are a valid/ack pair; buf_ready holds until an
// ack is seen in a cycle where buf_ready=1. s_valid has no back-pressure: a
// strobe is either accepted (FILL, en=1), dropped (STALL, en=1) or ignored
// (en=0).
// -----------------------------------------------------------------------------
module pingpong_buffer_ctrl
  import pingpong_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              ram_we,
  output logic [ADDR_W:0]   ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              buf_ready,
  output logic              rd_bank,
  input  logic              buf_ack,
  output logic              buffer_full,
  output logic              overflow_sticky,
`ifdef PINGPONG_DROP_CNT_EN
  output logic [15:0]       drop_count,
`endif
  output pp_state_t         dbg_state
);

  // ---------------------------------------------------------------------------
  // Write-side state
  // ---------------------------------------------------------------------------
  pp_state_t         state_q, state_d;
  bank_sel_t         wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  logic              ram_we_q, ram_we_d;
  logic [ADDR_W:0]   ram_waddr_q, ram_waddr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              sticky_q, sticky_d;

  logic              accept;
  logic              drop;
  logic              last_accept;
  logic              other_free;

  // Bank tracker interface
  logic [1:0]        bank_full;
  bank_sel_t         trk_rd_bank;
  logic              trk_buf_ready;
  logic              ack_fire;

  assign accept      = s_valid && en && (state_q == FILL);
  assign drop        = s_valid && en && (state_q == STALL);
  assign last_accept = accept && (wr_addr_q == ADDR_W'(DEPTH - 1));

  // The other bank counts as free if it is empty now, or if the consumer is
  // releasing it in this very cycle (ack wins over a simultaneous last write).
  assign other_free = !bank_full[other_bank(wr_bank_q)] ||
                      (ack_fire && (trk_rd_bank == other_bank(wr_bank_q)));

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    ram_we_d    = accept;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
    sticky_d    = sticky_q || drop;

    if (accept) begin
      ram_waddr_d = {wr_bank_q, wr_addr_q};
      ram_wdata_d = s_data;
    end

    unique case (state_q)
      FILL: begin
        if (accept) begin
          // DEPTH is a power of two, so the increment wraps to 0 on its own.
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          if (last_accept) begin
            // Toggle in both outcomes: when stalling, the toggled bank is the
            // older full one, which is exactly the next bank to be freed.
            wr_bank_d = other_bank(wr_bank_q);
            if (!other_free) begin
              state_d = STALL;
            end
          end
        end
      end
      STALL: begin
        // Any honoured ack here frees wr_bank; wr_addr is already 0.
        if (ack_fire) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      ram_we_q    <= ram_we_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
      sticky_q    <= sticky_d;
    end
  end

`ifdef PINGPONG_DROP_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating dropped-sample counter
  // ---------------------------------------------------------------------------
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  pingpong_bank_tracker u_tracker (
    .clk         (clk),
    .rst         (rst),
    .set_full_i  (last_accept),
    .set_bank_i  (wr_bank_q),
    .buf_ack_i   (buf_ack),
    .bank_full_o (bank_full),
    .rd_bank_o   (trk_rd_bank),
    .buf_ready_o (trk_buf_ready),
    .ack_fire_o  (ack_fire)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ram_we          = ram_we_q;
  assign ram_waddr       = ram_waddr_q;
  assign ram_wdata       = ram_wdata_q;
  assign buf_ready       = trk_buf_ready;
  assign rd_bank         = trk_rd_bank;
  assign buffer_full     = (state_q == STALL);
  assign overflow_sticky = sticky_q;
  assign dbg_state       = state_q;

endmodule

// File: doc/pingpong_buffer_ctrl.md
Name: pingpong_buffer_ctrl

Overview:
Controls the two-bank (ping-pong) sample RAM between the I2S capture path and the downstream consumer (VU meter / readout).
- Write side: accepts one sample per s_valid pulse, generates RAM write address, bank bit and write enable, and swaps banks when one is full.
- Read side: presents completed banks to the consumer in fill order with a ready/ack handshake.
- Flags overflow on buffer_full when both banks are full and unacknowledged.

Parameters:
DATA_W, 32, sample word width (24-bit audio plus 8-bit padding)
DEPTH, 256, samples per bank; power of two, at least 4
ADDR_W, $clog2(DEPTH), in-bank address width

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
en  input  1  capture enable; when low, s_valid is ignored and write position is held
s_valid  input  1  one-cycle strobe, new sample from I2S receiver
s_data  input  DATA_W  sample word
ram_we  output  1  RAM write enable
ram_waddr  output  ADDR_W+1  {bank, in-bank address}
ram_wdata  output  DATA_W  registered copy of s_data
buf_ready  output  1  a full bank is waiting for the consumer
rd_bank  output  1  bank the consumer must read while buf_ready=1
buf_ack  input  1  one-cycle pulse: consumer finished rd_bank
buffer_full  output  1  overflow: both banks full, samples being dropped
overflow_sticky  output  1  set on the first dropped sample; cleared only by rst

Behaviour:
- Decided: one clock, clk; reset rst is synchronous and active-high. Every register updates on posedge clk.
- Reset values: ram_we=0, ram_waddr=0, ram_wdata=0, buf_ready=0, rd_bank=0, buffer_full=0, overflow_sticky=0. Internal state: wr_bank=0, wr_addr=0, bank_full=2'b00, state FILL.
- FSM states:
  - FILL, writer has a free bank.
  - STALL, both banks full.
- Accept rule: a sample is accepted when s_valid && en && state==FILL.
- Accepted sample at cycle n: at n+1, ram_we=1, ram_waddr={wr_bank, wr_addr}, ram_wdata=s_data. In all other cycles ram_we=0.
- wr_addr increments per accepted sample. When wr_addr==DEPTH-1 is accepted:
  - wr_addr wraps to 0 and bank_full[wr_bank] is set.
  - If bank_full[~wr_bank]==0, wr_bank toggles and state stays FILL.
  - Otherwise state goes to STALL; wr_bank toggles, pointing at the oldest bank, the next to be freed.
- buf_ready is registered: buf_ready = bank_full[rd_bank], so it rises 2 cycles after the last sample is accepted (after the final RAM write).
- buf_ack: while buf_ready=1, clears bank_full[rd_bank] and toggles rd_bank, so banks are handed out in fill order.
  - buf_ack while buf_ready=0 is ignored.
  - If the other bank is also full, buf_ready stays 1 with the new rd_bank.
- STALL:
  - buffer_full=1.
  - Each s_valid&&en is dropped and sets overflow_sticky.
  - On buf_ack, the freed bank equals wr_bank; return to FILL the next cycle and resume at address 0 of that bank.
- Simultaneous last-sample accept and buf_ack in the same cycle: the ack is processed first. The freed bank counts as free, so no STALL is entered.
- s_valid while en=0: ignored and not counted as a drop. Deasserting en mid-bank holds wr_addr; capture resumes at the same address.
- rst mid-operation: all state returns to reset values; partial bank contents are abandoned.

Optional Feature:
PINGPONG_DROP_CNT_EN
- Defined: adds output drop_count [15:0], reset 0. It increments once per dropped sample in STALL and saturates at 16'hFFFF.
- Undefined: port and counter absent; overflow reporting is only buffer_full and overflow_sticky.

Decomposition:
- Package pingpong_pkg: typedef enum {FILL, STALL} pp_state_t, plus helper typedef bank_sel_t (1 bit). DEPTH/DATA_W defaults live there as localparams, shared with the top and the RAM.
- One sub-module, pingpong_bank_tracker: owns bank_full[1:0], rd_bank, buf_ready and ack handling. The main module keeps the write FSM and address generation.

Test Plan:
1. Reset, then DEPTH=4 with 4 samples 0x100000..0x100003 at rate 1/8 -> ram_waddr 0,1,2,3, ram_wdata matches; buf_ready=1, rd_bank=0 two cycles after the 4th accept.
2. Continue 4 more samples without ack -> writes go to addresses 4..7 (bank 1); then 2 more samples -> buffer_full=1, overflow_sticky=1, no ram_we; with the option enabled, drop_count=2.
3. From test 2, pulse buf_ack -> rd_bank=1, buf_ready stays 1, buffer_full=0 next cycle; next sample is written to ram_waddr 0.
4. Last sample of bank 1 and buf_ack for bank 0 in the same cycle -> no STALL, buffer_full stays 0, writer moves to bank 0.
5. en=0 after 2 samples, 5 s_valid pulses, then en=1 -> no ram_we while disabled, next write at address 2, overflow_sticky=0.
6. Assert rst mid-bank (address 3 of bank 1, bank 0 full) -> all outputs return to reset values the next cycle; the next sample is written to ram_waddr 0.
